// File: rtl/n64_controller_responder.sv
// n64_controller_responder: the controller end of the N64 one-wire bus on an open-drain pin.
// It decodes console commands and replies with the status word or the APB-written button word.
// Build option: define N64_RESP_STATS_EN to add the POLLS (0x0C) and BADCMD (0x10) counters.
module n64_controller_responder #(
    parameter int CYC_PER_US   = 100,
    parameter int REPLY_GAP_US = 2,
    parameter int TIMEOUT_US   = 8
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    inout  wire         fab_pin
);
    localparam int T_CYC   = CYC_PER_US;
    localparam int GAP_CYC = REPLY_GAP_US * CYC_PER_US;
    localparam int TO_CYC  = TIMEOUT_US * CYC_PER_US;
    localparam int CW      = $clog2(TO_CYC + GAP_CYC + 4 * T_CYC + 1);

    localparam logic [CW-1:0] C_1T     = CW'(T_CYC);
    localparam logic [CW-1:0] C_2T     = CW'(2 * T_CYC);
    localparam logic [CW-1:0] C_3T     = CW'(3 * T_CYC);
    localparam logic [CW-1:0] C_2T_M1  = CW'(2 * T_CYC - 1);
    localparam logic [CW-1:0] C_4T_M1  = CW'(4 * T_CYC - 1);
    localparam logic [CW-1:0] C_GAP_M1 = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] C_TO     = CW'(TO_CYC);
    localparam logic [CW-1:0] C_TO_M1  = CW'(TO_CYC - 1);
    localparam logic [CW-1:0] C_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_RX_BIT, S_RX_STOP, S_GAP, S_TX_BIT, S_TX_STOP, S_ABORT
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    sync_q, sync_d;          // [0],[1] synchroniser, [2] previous value of [1]
    logic [CW-1:0] cnt_q, cnt_d;            // cycles since cell start / phase start
    logic [4:0]    bit_q, bit_d;
    logic          pend_q, pend_d;          // a cell has started and is not yet sampled
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    last_cmd_q, last_cmd_d;
    logic [31:0]   tx_q, tx_d;              // reply shadow, MSB is the bit on the wire
    logic [4:0]    last_idx_q, last_idx_d;
    logic          drive_q, drive_d;
    logic [31:0]   buttons_q, buttons_d;
    logic          en_q, en_d;
    logic          line, fall, rise, inc_poll, inc_bad, apb_wr, tx_active, busy;
    logic [15:0]   polls_rd;
    logic [7:0]    bad_rd;

    assign sync_d    = {sync_q[1:0], fab_pin};
    assign line      = sync_q[1];
    assign fall      = sync_q[2] & ~sync_q[1];
    assign rise      = ~sync_q[2] & sync_q[1];
    assign busy      = (state_q != S_IDLE);
    assign tx_active = (state_q == S_TX_BIT) || (state_q == S_TX_STOP);
    assign fab_pin   = drive_q ? 1'b0 : 1'bz;
    assign apb_wr    = PSEL & PENABLE & PWRITE;
    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;

    // Bus FSM: next state, cell counter, shift registers and line drive.
    always_comb begin
        // NOTE: every _d gets its default first, so no branch can leave a latch behind.
        state_d    = state_q;
        cnt_d      = (cnt_q == C_MAX) ? cnt_q : cnt_q + CW'(1);
        bit_d      = bit_q;
        pend_d     = pend_q;
        rx_d       = rx_q;
        last_cmd_d = last_cmd_q;
        tx_d       = tx_q;
        last_idx_d = last_idx_q;
        drive_d    = 1'b0;
        inc_poll   = 1'b0;
        inc_bad    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_q && fall) begin
                    state_d = S_RX_BIT;
                    cnt_d   = '0;
                    pend_d  = 1'b1;
                    bit_d   = '0;
                end
            end
            S_RX_BIT: begin
                if (fall) begin
                    pend_d = 1'b1;
                    cnt_d  = '0;
                end else if (pend_q && cnt_q == C_2T) begin
                    rx_d   = {rx_q[6:0], line};
                    pend_d = 1'b0;
                    bit_d  = bit_q + 5'd1;
                    if (bit_q == 5'd7) begin
                        state_d    = S_RX_STOP;
                        last_cmd_d = {rx_q[6:0], line};
                    end
                end else if (cnt_q >= C_TO) begin
                    state_d = S_ABORT;
                    cnt_d   = '0;
                    inc_bad = 1'b1;
                end
            end
            S_RX_STOP: begin
                if (fall) begin
                    pend_d = 1'b1;
                    cnt_d  = '0;
                end else if (pend_q && rise) begin
                    // Short stop pulse: the reply gap is timed from this release.
                    cnt_d  = '0;
                    pend_d = 1'b0;
                    case (last_cmd_q)
                        8'h00, 8'hFF: begin
                            state_d    = S_GAP;
                            tx_d       = 32'h0500_0200;
                            last_idx_d = 5'd23;
                        end
                        8'h01: begin
                            state_d    = S_GAP;
                            tx_d       = buttons_q;
                            last_idx_d = 5'd31;
                        end
                        default: begin
                            state_d = S_IDLE;
                            inc_bad = 1'b1;
                        end
                    endcase
                end else if ((pend_q && cnt_q >= C_2T) || cnt_q >= C_TO) begin
                    // Still low at the sample point means a ninth data bit, not a stop.
                    state_d = S_ABORT;
                    cnt_d   = '0;
                    inc_bad = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == C_GAP_M1) begin
                    state_d = S_TX_BIT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_TX_BIT: begin
                drive_d = (cnt_q < (tx_q[31] ? C_1T : C_3T));
                if (cnt_q == C_4T_M1) begin
                    cnt_d = '0;
                    tx_d  = {tx_q[30:0], 1'b0};
                    if (bit_q == last_idx_q) state_d = S_TX_STOP;
                    else                     bit_d   = bit_q + 5'd1;
                end
            end
            S_TX_STOP: begin
                drive_d = 1'b1;
                if (cnt_q == C_2T_M1) begin
                    state_d  = S_IDLE;
                    inc_poll = 1'b1;
                end
            end
            S_ABORT: begin
                if (!line)                  cnt_d   = '0;
                else if (cnt_q == C_TO_M1)  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // APB register writes.
    always_comb begin
        buttons_d = buttons_q;
        en_d      = en_q;
        if (apb_wr && PADDR[4:2] == 3'd0) buttons_d = PWDATA;
        if (apb_wr && PADDR[4:2] == 3'd1) en_d      = PWDATA[0];
    end

    // State and register flops; reset also releases the pin at once.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        // NOTE: data registers are reset along with control state, so every readback after reset is defined.
        if (!PRESERN) begin
            state_q    <= S_IDLE;
            sync_q     <= 3'b111;
            cnt_q      <= '0;
            bit_q      <= '0;
            pend_q     <= 1'b0;
            rx_q       <= '0;
            last_cmd_q <= '0;
            tx_q       <= '0;
            last_idx_q <= '0;
            drive_q    <= 1'b0;
            buttons_q  <= '0;
            en_q       <= 1'b0;
        end else begin
            // NOTE: flops take <= so every register samples the pre-edge values of its neighbours.
            state_q    <= state_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            pend_q     <= pend_d;
            rx_q       <= rx_d;
            last_cmd_q <= last_cmd_d;
            tx_q       <= tx_d;
            last_idx_q <= last_idx_d;
            drive_q    <= drive_d;
            buttons_q  <= buttons_d;
            en_q       <= en_d;
        end
    end

`ifdef N64_RESP_STATS_EN
    logic [15:0] polls_q, polls_d;
    logic [7:0]  bad_q, bad_d;

    // Statistics counters; a clear write beats a same-cycle increment.
    always_comb begin
        polls_d = polls_q;
        bad_d   = bad_q;
        if (apb_wr && PADDR[4:2] == 3'd3) begin
            polls_d = '0;
            bad_d   = '0;
        end else begin
            if (inc_poll)                   polls_d = polls_q + 16'd1;
            if (inc_bad && bad_q != 8'hFF)  bad_d   = bad_q + 8'd1;
        end
    end

    // Statistics counter flops.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            polls_q <= '0;
            bad_q   <= '0;
        end else begin
            polls_q <= polls_d;
            bad_q   <= bad_d;
        end
    end

    assign polls_rd = polls_q;
    assign bad_rd   = bad_q;
`else
    logic unused_stats;
    assign unused_stats = inc_poll ^ inc_bad;
    assign polls_rd     = '0;
    assign bad_rd       = '0;
`endif

    logic unused_addr;
    assign unused_addr = ^{PADDR[31:5], PADDR[1:0]};

    // APB read mux, combinational from the word address.
    always_comb begin
        PRDATA = '0;
        case (PADDR[4:2])
            3'd0:    PRDATA = buttons_q;
            3'd1:    PRDATA = {31'd0, en_q};
            3'd2:    PRDATA = {16'd0, last_cmd_q, 6'd0, tx_active, busy};
            3'd3:    PRDATA = {16'd0, polls_rd};
            3'd4:    PRDATA = {24'd0, bad_rd};
            default: PRDATA = '0;
        endcase
    end
endmodule

// File: tb/tb_n64_controller_responder.sv
// Directed bench for n64_controller_responder: a console model on a pulled-up open-drain line,
// APB register access, and reply decoding with exact cell timing checks.
`timescale 1ns/1ps
module tb_n64_controller_responder;
    localparam int CYC = 100;

    logic        PCLK    = 1'b0;
    logic        PRESERN = 1'b0;
    logic        PSEL    = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE  = 1'b0;
    logic [31:0] PADDR   = '0;
    logic [31:0] PWDATA  = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    wire         fab_pin;
    logic        con_drv = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    assign fab_pin = con_drv ? 1'b0 : 1'bz;
    pullup (fab_pin);

    always #5 PCLK = ~PCLK;

    n64_controller_responder #(.CYC_PER_US(CYC), .REPLY_GAP_US(2), .TIMEOUT_US(8)) dut (
        .PCLK    (PCLK),
        .PRESERN (PRESERN),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .fab_pin (fab_pin)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 d = PRDATA;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Console bit: '0' is 3us low + 1us high, '1' is 1us low + 3us high.
    task automatic send_bit(input logic b);
        con_drv = 1'b1;
        repeat (b ? CYC : 3 * CYC) @(negedge PCLK);
        con_drv = 1'b0;
        repeat (b ? 3 * CYC : CYC) @(negedge PCLK);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) send_bit(c[i]);
        con_drv = 1'b1;
        repeat (CYC) @(negedge PCLK);
        con_drv = 1'b0;
    endtask

    // Count negedge samples on which the line is not high (i.e. someone drives it).
    task automatic watch_quiet(input int n, output int driven);
        driven = 0;
        repeat (n) begin
            @(negedge PCLK);
            if (fab_pin !== 1'b1) driven++;
        end
    endtask

    // Decode a reply; timing errors count cells whose low/high lengths differ from the expected bit.
    task automatic capture(input int nbits, input logic [31:0] exp_word, output logic [31:0] word,
                           output int gap, output int stop_len, output int terr);
        int   lo;
        int   hi;
        logic eb;
        word = '0; terr = 0; stop_len = 0;
        @(negedge PCLK);
        gap = 1;
        while (fab_pin !== 1'b0 && gap < 2000) begin @(negedge PCLK); gap++; end
        for (int i = 0; i <= nbits; i++) begin
            lo = 0;
            while (fab_pin === 1'b0 && lo < 2000) begin @(negedge PCLK); lo++; end
            if (i == nbits) begin
                stop_len = lo;
            end else begin
                hi = 0;
                while (fab_pin !== 1'b0 && hi < 2000) begin @(negedge PCLK); hi++; end
                word = {word[30:0], (lo < 2 * CYC)};
                eb   = exp_word[nbits - 1 - i];
                if (lo != (eb ? CYC : 3 * CYC) || hi != (eb ? 3 * CYC : CYC)) terr++;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] word;
        int          gap;
        int          stop_len;
        int          terr;
        int          cnt;

        // Reset state
        repeat (4) @(negedge PCLK);
        check("rst_pin_released", {31'd0, fab_pin}, 32'd1);
        PRESERN = 1'b1;
        apb_read(32'h0, rd);  check("rst_buttons", rd, 32'h0);
        apb_read(32'h4, rd);  check("rst_ctrl", rd, 32'h0);
        apb_read(32'h8, rd);  check("rst_status", rd, 32'h0);
        check("pready_pslverr", {30'd0, PREADY, PSLVERR}, 32'h2);

        // 1: status command
        apb_write(32'h4, 32'h1);
        apb_read(32'h4, rd);  check("ctrl_en", rd, 32'h1);
        send_cmd(8'h00);
        capture(24, 32'h050002, word, gap, stop_len, terr);
        check("status_reply", word, 32'h050002);
        check("status_gap_2us", {31'd0, (gap >= 195 && gap <= 215)}, 32'd1);
        check("status_bit_timing_errs", terr, 32'd0);
        check("status_stop_len", stop_len, 32'd200);
        apb_read(32'h8, rd);  check("status_after_reply", rd, 32'h0);

        // 2+3: poll, BUTTONS rewritten mid-reply keeps the old word on the wire
        apb_write(32'h0, 32'h8000_7F80);
        send_cmd(8'h01);
        fork
            capture(32, 32'h8000_7F80, word, gap, stop_len, terr);
            begin
                repeat (4000) @(negedge PCLK);
                apb_write(32'h0, 32'h0000_0001);
            end
        join
        check("poll_reply_shadowed", word, 32'h8000_7F80);
        check("poll_bit_timing_errs", terr, 32'd0);
        apb_read(32'h8, rd);  check("status_last_cmd_01", rd, 32'h0100);
        send_cmd(8'h01);
        capture(32, 32'h0000_0001, word, gap, stop_len, terr);
        check("poll_reply_new", word, 32'h0000_0001);
        check("poll2_bit_timing_errs", terr, 32'd0);
`ifdef N64_RESP_STATS_EN
        apb_read(32'hC, rd);  check("polls_3", rd, 32'd3);
`endif

        // 4: line held low 10us mid-command aborts without any reply
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        con_drv = 1'b1;
        repeat (10 * CYC) @(negedge PCLK);
        con_drv = 1'b0;
        repeat (5) @(negedge PCLK);
        apb_read(32'h8, rd);  check("abort_busy", rd, 32'h0101);
        watch_quiet(900, cnt);
        check("abort_no_drive", cnt, 32'd0);
        apb_read(32'h8, rd);  check("abort_back_idle", rd, 32'h0100);
`ifdef N64_RESP_STATS_EN
        apb_read(32'h10, rd); check("badcmd_1", rd, 32'd1);
`endif

        // Unknown command: no reply, back to idle
        send_cmd(8'h55);
        watch_quiet(1500, cnt);
        check("unknown_no_drive", cnt, 32'd0);
        apb_read(32'h8, rd);  check("unknown_status", rd, 32'h5500);
`ifdef N64_RESP_STATS_EN
        apb_read(32'h10, rd); check("badcmd_2", rd, 32'd2);
        apb_write(32'hC, 32'h0);
        apb_read(32'hC, rd);  check("polls_cleared", rd, 32'd0);
        apb_read(32'h10, rd); check("badcmd_cleared", rd, 32'd0);
`else
        apb_write(32'hC, 32'hFFFF_FFFF);
        apb_read(32'hC, rd);  check("no_stats_polls", rd, 32'd0);
        apb_read(32'h10, rd); check("no_stats_badcmd", rd, 32'd0);
`endif

        // 5: disabled responder ignores a poll
        apb_write(32'h4, 32'h0);
        send_cmd(8'h01);
        watch_quiet(1500, cnt);
        check("disabled_no_drive", cnt, 32'd0);
        apb_read(32'h8, rd);  check("disabled_status", rd, 32'h5500);

        // 6: reset mid-reply releases the pin immediately
        apb_write(32'h4, 32'h1);
        send_cmd(8'h01);
        @(negedge PCLK);
        cnt = 0;
        while (fab_pin !== 1'b0 && cnt < 3000) begin @(negedge PCLK); cnt++; end
        check("rst_tx_started", {31'd0, (cnt < 3000)}, 32'd1);
        apb_read(32'h8, rd);  check("tx_status", rd, 32'h0103);
        @(negedge PCLK);
        PRESERN = 1'b0;
        #1 check("rst_mid_tx_released", {31'd0, fab_pin}, 32'd1);
        repeat (3) @(negedge PCLK);
        PRESERN = 1'b1;
        apb_read(32'h0, rd);  check("post_rst_buttons", rd, 32'h0);
        apb_read(32'h4, rd);  check("post_rst_ctrl", rd, 32'h0);
        apb_read(32'h8, rd);  check("post_rst_status", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
